// File: rtl/weight_ram_param_if.sv
// rtl/weight_ram_param_if.sv - request/response bundle for the weight RAM
interface weight_ram_param_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 5
);
  logic              init;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d;
  logic              we;
  logic              re;
  logic              acc;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              busy;
  logic              done;
  logic              addr_err;

  modport master (
    output init, addr, d, we, re, acc,
    input  q, q_valid, busy, done, addr_err
  );

  modport slave (
    input  init, addr, d, we, re, acc,
    output q, q_valid, busy, done, addr_err
  );
endinterface

// File: rtl/weight_ram_param.sv
// rtl/weight_ram_param.sv - weight store with init sequencer; WEIGHT_RAM_SAT_ACC_EN enables saturating accumulate-on-write
module weight_ram_param #(
  parameter int  DATA_W = 10,
  parameter int  DEPTH  = 30,
  parameter int  GROUP  = 10,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  weight_ram_param_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_READY} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] GLAST_C = ADDR_W'(GROUP - 1);

  // Alternating pattern with the MSB set (10 bits: 10_1010_1010)
  function automatic logic [DATA_W-1:0] alt_msb_one();
    logic [DATA_W-1:0] p;
    for (int i = 0; i < DATA_W; i++) p[i] = (((DATA_W - 1 - i) % 2) == 0);
    return p;
  endfunction

  localparam logic [DATA_W-1:0] PAT_A = alt_msb_one();
  localparam logic [DATA_W-1:0] PAT_B = ~PAT_A;
  localparam logic [DATA_W-1:0] PAT_U = {DATA_W{1'b1}} << (DATA_W - DATA_W / 2);

  state_t            state_q;
  logic [ADDR_W-1:0] iaddr_q;   // init write address
  logic [ADDR_W-1:0] gcnt_q;    // position inside the current group
  logic [1:0]        gidx_q;    // group index, saturates at 2
  logic [DATA_W-1:0] q_q;
  logic              qv_q, busy_q, done_q, err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_range;
  logic              running;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] init_word;
  logic [DATA_W-1:0] wr_word;

  assign in_range = ({1'b0, bus.addr} < DEPTH_C);
  assign running  = (state_q == S_INIT);

  // Default pattern for the word the sequencer is writing this cycle
  always_comb begin
    init_word = PAT_U;
    case (gidx_q)
      2'd0:    init_word = iaddr_q[0] ? PAT_B : PAT_A;
      2'd1:    init_word = PAT_B;
      default: init_word = PAT_U;
    endcase
  end

`ifdef WEIGHT_RAM_SAT_ACC_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic [DATA_W:0]   acc_sum;
  logic [DATA_W-1:0] old_word;

  // Signed read-modify-write sum, clamped when the carry disagrees with the sign
  always_comb begin
    old_word = mem_q[bus.addr];
    acc_sum  = {old_word[DATA_W-1], old_word} + {bus.d[DATA_W-1], bus.d};
    if (!bus.acc) begin
      wr_word = bus.d;
    end else if (acc_sum[DATA_W] != acc_sum[DATA_W-1]) begin
      wr_word = acc_sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      wr_word = acc_sum[DATA_W-1:0];
    end
  end
`else
  logic unused_acc;
  assign unused_acc = bus.acc;
  assign wr_word    = bus.d;
`endif

  // Single array write port shared by the sequencer and the user path
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.addr;
    mem_wdata = wr_word;
    if (running) begin
      mem_we    = 1'b1;
      mem_addr  = iaddr_q;
      mem_wdata = init_word;
    end else begin
      mem_we    = bus.we && in_range;
    end
  end

  // Storage array; contents are deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // Control FSM with registered read data, status and error pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      iaddr_q <= '0;
      gcnt_q  <= '0;
      gidx_q  <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      qv_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_INIT: begin
          if (iaddr_q == LAST_C) begin
            state_q <= S_READY;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          iaddr_q <= iaddr_q + ADDR_W'(1);
          if (gcnt_q == GLAST_C) begin
            gcnt_q <= '0;
            if (gidx_q != 2'd2) gidx_q <= gidx_q + 2'd1;
          end else begin
            gcnt_q <= gcnt_q + ADDR_W'(1);
          end
        end
        default: begin
          if (bus.init) begin
            state_q <= S_INIT;
            busy_q  <= 1'b1;
            iaddr_q <= '0;
            gcnt_q  <= '0;
            gidx_q  <= '0;
          end
          if ((bus.we || bus.re) && !in_range) err_q <= 1'b1;
          if (bus.re && !bus.we) begin
            qv_q <= 1'b1;
            q_q  <= in_range ? mem_q[bus.addr] : '0;
          end
        end
      endcase
    end
  end

  assign bus.q        = q_q;
  assign bus.q_valid  = qv_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.addr_err = err_q;

endmodule
